// File: rtl/encryptor_pkg.sv
// ----------------------------------------------------------------------------
// encryptor_pkg
//   Shared constants and types for the encryptor datapath and its
//   block serializer.
//   Contents:
//     BLOCK_BYTES    - bytes per 64-bit block
//     LAST_BYTE_IDX  - byte count value of the final block byte
//     CRC8_POLY      - CRC-8 polynomial (x^8 + x^2 + x + 1)
//     CRC8_INIT      - CRC-8 initial value
//     ser_state_e    - serializer FSM state encoding
// ----------------------------------------------------------------------------
package encryptor_pkg;

  localparam int          BLOCK_BYTES   = 8;
  localparam logic [2:0]  LAST_BYTE_IDX = 3'(BLOCK_BYTES - 1);
  localparam logic [7:0]  CRC8_POLY     = 8'h07;
  localparam logic [7:0]  CRC8_INIT     = 8'h00;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_ACK  = 2'd1,
    SER_SEND = 2'd2,
    SER_CRC  = 2'd3
  } ser_state_e;

endpackage : encryptor_pkg

// File: rtl/crc8_update.sv
// ----------------------------------------------------------------------------
// crc8_update
//   Combinational CRC-8 step: folds one data byte (MSB first) into the
//   running CRC. Polynomial CRC8_POLY, no reflection, no output xor.
//   Ports:
//     crc_i  [7:0] - current CRC value
//     data_i [7:0] - byte being absorbed
//     crc_o  [7:0] - CRC after absorbing data_i
// ----------------------------------------------------------------------------
module crc8_update
  import encryptor_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] work;

  // Xoring the whole byte in first and then running eight shift steps is
  // equivalent to feeding the byte bit by bit into the register.
  always_comb begin
    work = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (work[7]) begin
        work = {work[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        work = {work[6:0], 1'b0};
      end
    end
    crc_o = work;
  end

endmodule : crc8_update

// File: rtl/trans_block_serializer.sv
// ----------------------------------------------------------------------------
// trans_block_serializer
//   Takes finished 64-bit blocks from encryptor_core through a four-phase
//   trans_data_ready / handshake_ack handshake and streams each block
//   MSB byte first over a valid/ready byte interface.
//
//   Build option: define SERIALIZER_CRC8_EN to append a CRC-8 trailer byte
//   (poly 0x07, init 0x00) computed over the 8 block bytes in send order.
//
//   Ports:
//     clk               in      - system clock, rising edge
//     n_rst             in      - asynchronous active-low reset
//     trans_data        in  64  - block from the core, valid with request
//     trans_data_ready  in      - core request, level, held until acked
//     handshake_ack     out     - block latched; high while in ACK
//     tx_byte           out 8   - outgoing byte
//     tx_valid          out     - tx_byte valid
//     tx_ready          in      - downstream accepts on valid && ready
//     tx_last           out     - marks final byte of the block
//     busy              out     - serializer not idle
// ----------------------------------------------------------------------------
module trans_block_serializer
  import encryptor_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] trans_data,
  input  logic        trans_data_ready,
  output logic        handshake_ack,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy
);

  ser_state_e  state_q, state_d;
  logic [63:0] shift_q, shift_d;
  logic [2:0]  count_q, count_d;

`ifdef SERIALIZER_CRC8_EN
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  crc_next;

  // The byte on the wire is always shift_q[63:56], so the CRC can be
  // advanced from it directly on every accept.
  crc8_update u_crc8_update (
    .crc_i  (crc_q),
    .data_i (shift_q[63:56]),
    .crc_o  (crc_next)
  );
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= SER_IDLE;
      shift_q <= '0;
      count_q <= '0;
`ifdef SERIALIZER_CRC8_EN
      crc_q   <= CRC8_INIT;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
`ifdef SERIALIZER_CRC8_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // In SEND and CRC tx_valid is always high, so tx_ready alone is an accept.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
`ifdef SERIALIZER_CRC8_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      SER_IDLE: begin
        if (trans_data_ready) begin
          state_d = SER_ACK;
          shift_d = trans_data;
          count_d = '0;
`ifdef SERIALIZER_CRC8_EN
          crc_d   = CRC8_INIT;
`endif
        end
      end

      // Four-phase: wait for the core to drop its request before sending.
      SER_ACK: begin
        if (!trans_data_ready) begin
          state_d = SER_SEND;
        end
      end

      SER_SEND: begin
        if (tx_ready) begin
          shift_d = {shift_q[55:0], 8'h00};
          count_d = count_q + 3'd1;
`ifdef SERIALIZER_CRC8_EN
          crc_d   = crc_next;
`endif
          if (count_q == LAST_BYTE_IDX) begin
`ifdef SERIALIZER_CRC8_EN
            state_d = SER_CRC;
`else
            state_d = SER_IDLE;
`endif
          end
        end
      end

      SER_CRC: begin
`ifdef SERIALIZER_CRC8_EN
        if (tx_ready) begin
          state_d = SER_IDLE;
        end
`else
        state_d = SER_IDLE;
`endif
      end

      default: state_d = SER_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (registers only, no input-to-output paths)
  // --------------------------------------------------------------------------
  always_comb begin
    handshake_ack = 1'b0;
    tx_byte       = 8'h00;
    tx_valid      = 1'b0;
    tx_last       = 1'b0;
    busy          = (state_q != SER_IDLE);
    case (state_q)
      SER_ACK: begin
        handshake_ack = 1'b1;
      end
      SER_SEND: begin
        tx_valid = 1'b1;
        tx_byte  = shift_q[63:56];
`ifndef SERIALIZER_CRC8_EN
        tx_last  = (count_q == LAST_BYTE_IDX);
`endif
      end
      SER_CRC: begin
`ifdef SERIALIZER_CRC8_EN
        tx_valid = 1'b1;
        tx_byte  = crc_q;
        tx_last  = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

endmodule : trans_block_serializer
